// File: rtl/product_accumulator.sv
// Sums each group of COUNT unsigned products into one saturating ACC_W-bit result,
// taking products on an input valid/ready port and presenting results on an output port.
module product_accumulator #(
  parameter int PROD_W = 8,
  parameter int COUNT  = 4,
  parameter int ACC_W  = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_product,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic              out_overflow,
  output logic              busy,
  output logic              dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both
  // high. in_ready and out_valid are pure decodes of the state register, so the
  // two ports are never ready/valid in the same cycle and neither depends on the
  // other side's signals combinationally.

  localparam int CNT_W = $clog2(COUNT);
  localparam int SUM_W = ((ACC_W > PROD_W) ? ACC_W : PROD_W) + 1;
  localparam logic [SUM_W-1:0] ACC_MAX  = (SUM_W'(1) << ACC_W) - SUM_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT - 1);

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_DONE  = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               ovf_q, ovf_d;
  logic [ACC_W-1:0]   out_sum_q, out_sum_d;
  logic               out_ovf_q, out_ovf_d;

  logic [SUM_W-1:0]   sum_wide;
  logic               sat_hit;
  logic [ACC_W-1:0]   sum_sat;
  logic               accept;

  always_comb begin
    sum_wide = SUM_W'(acc_q) + SUM_W'(in_product);
    sat_hit  = (sum_wide > ACC_MAX);
    sum_sat  = sat_hit ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
    accept   = in_valid && (state_q == ST_ACCUM);
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    ovf_d     = ovf_q;
    out_sum_d = out_sum_q;
    out_ovf_d = out_ovf_q;

    // clear outranks both handshakes; out_sum is left as-is since out_valid drops.
    if (clear) begin
      state_d   = ST_ACCUM;
      acc_d     = '0;
      cnt_d     = '0;
      busy_d    = 1'b0;
      ovf_d     = 1'b0;
      out_ovf_d = 1'b0;
    end else begin
      case (state_q)
        ST_ACCUM: begin
          if (accept) begin
            if (cnt_q == CNT_LAST) begin
              out_sum_d = sum_sat;
              out_ovf_d = ovf_q | sat_hit;
              state_d   = ST_DONE;
              acc_d     = '0;
              cnt_d     = '0;
              busy_d    = 1'b0;
              ovf_d     = 1'b0;
            end else begin
              acc_d  = sum_sat;
              cnt_d  = cnt_q + 1'b1;
              busy_d = 1'b1;
              ovf_d  = ovf_q | sat_hit;
            end
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_d = ST_ACCUM;
          end
        end
        default: begin
          state_d = ST_ACCUM;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_ACCUM;
      acc_q     <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      ovf_q     <= 1'b0;
      out_sum_q <= '0;
      out_ovf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      ovf_q     <= ovf_d;
      out_sum_q <= out_sum_d;
      out_ovf_q <= out_ovf_d;
    end
  end

  assign in_ready     = (state_q == ST_ACCUM);
  assign out_valid    = (state_q == ST_DONE);
  assign out_sum      = out_sum_q;
  assign out_overflow = out_ovf_q;
  assign busy         = busy_q;
  assign dbg_state    = state_q;

endmodule
